// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the two-requester SPI arbiter.
//   state_t         arbiter FSM states
//   NUM_REQ, CMD_W  requester count and SPI command/data width
//   idx_to_onehot   requester index -> one-hot grant vector
package spi_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned CMD_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arb_if.sv
// spi_arb_if: bundles the requester-side and SPI-master-side signals of spi_arb.
//   req/cmd0/cmd1        requester requests and command words
//   gnt/done/rdata/err   grant, completion pulse, read word, timeout pulse
//   spi_wrt/spi_cmd      start pulse and command to the SPI master
//   spi_rdy/spi_rdata    SPI master ready and read data
//   modport master: arbiter side; modport slave: environment side.
interface spi_arb_if;
    import spi_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [CMD_W-1:0]   cmd0;
    logic [CMD_W-1:0]   cmd1;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [CMD_W-1:0]   rdata;
    logic               err;
    logic               spi_wrt;
    logic [CMD_W-1:0]   spi_cmd;
    logic               spi_rdy;
    logic [CMD_W-1:0]   spi_rdata;

    modport master (
        input  req, cmd0, cmd1, spi_rdy, spi_rdata,
        output gnt, done, rdata, err, spi_wrt, spi_cmd
    );

    modport slave (
        output req, cmd0, cmd1, spi_rdy, spi_rdata,
        input  gnt, done, rdata, err, spi_wrt, spi_cmd
    );

endinterface

// File: rtl/spi_arb_rr_pick.sv
// rr_pick: combinational 2-way round-robin winner select.
//   req      per-requester request bits
//   last_gnt index of the requester served last
//   win_c    index of the winner (valid when any_c)
//   any_c    at least one request pending
module rr_pick
    import spi_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic               win_c,
    output logic               any_c
);

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        any_c = |req;
        win_c = req[1];
        if (req == 2'b11) begin
            win_c = ~last_gnt;
        end
    end

endmodule

// File: rtl/spi_arb.sv
// spi_arb: arbitrates two requesters onto a single SPI master.
//   clk, rst_n  system clock, synchronous active-low reset
//   bus         spi_arb_if.master: req/cmd0/cmd1 in, gnt/done/rdata/err out,
//               spi_wrt/spi_cmd to the SPI master, spi_rdy/spi_rdata from it
// Optional macro SPI_ARB_TIMEOUT_EN: aborts a WAIT lasting TO_CYCLES cycles,
// pulsing err with done and leaving rdata unchanged.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_arb_if.master  bus
);

    state_t             state;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [CMD_W-1:0]   rdata_q;
    logic               spi_wrt_q;
    logic [CMD_W-1:0]   spi_cmd_q;
    logic               winner_q;
    logic               last_gnt_q;
    logic               win_c;
    logic               any_c;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [CNT_W-1:0] to_cnt_q;
    logic             err_q;
`endif

    rr_pick u_rr_pick (
        .req      (bus.req),
        .last_gnt (last_gnt_q),
        .win_c    (win_c),
        .any_c    (any_c)
    );

    // Arbiter FSM; winner and spi_cmd are frozen from IDLE exit until RELEASE exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            spi_wrt_q  <= 1'b0;
            spi_cmd_q  <= '0;
            winner_q   <= 1'b0;
            last_gnt_q <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done_q    <= '0;
            spi_wrt_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    gnt_q <= '0;
                    if (any_c) begin
                        winner_q  <= win_c;
                        spi_cmd_q <= win_c ? bus.cmd1 : bus.cmd0;
                        gnt_q     <= idx_to_onehot(win_c);
                        // Registered so the pulse coincides with the ISSUE cycle.
                        spi_wrt_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.spi_rdy) begin
                        rdata_q <= bus.spi_rdata;
                        done_q  <= gnt_q;
                        state   <= RELEASE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_cnt_q == CNT_W'(TO_CYCLES - 1)) begin
                        done_q <= gnt_q;
                        err_q  <= 1'b1;
                        state  <= RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    gnt_q      <= '0;
                    last_gnt_q <= winner_q;
                    state      <= IDLE;
                end
                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.spi_wrt = spi_wrt_q;
    assign bus.spi_cmd = spi_cmd_q;

`ifdef SPI_ARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    // No timeout: err is constant; TO_CYCLES is kept so both builds share one parameter list.
    assign bus.err = (TO_CYCLES > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 1024: number of WAIT cycles before a timeout abort (used only with SPI_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1: the single system clock; all flops on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 2: per-requester level request; bit0 = dump engine, bit1 = command/calibration engine.
REQ-005 SHALL have port cmd0, input, 16: SPI command word of requester 0.
REQ-006 SHALL have port cmd1, input, 16: SPI command word of requester 1.
REQ-007 SHALL have port gnt, output, 2: one-hot grant, held for the whole transaction.
REQ-008 SHALL have port done, output, 2: one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rdata, output, 16: SPI read word of the last completed transaction.
REQ-010 SHALL have port err, output, 1: one-cycle timeout pulse, coincident with done.
REQ-011 SHALL have port spi_wrt, output, 1: one-cycle start pulse to the SPI master.
REQ-012 SHALL have port spi_cmd, output, 16: command word to the SPI master.
REQ-013 SHALL have port spi_rdy, input, 1: high when the SPI master is idle or finished; master drops it the cycle after spi_wrt.
REQ-014 SHALL have port spi_rdata, input, 16: SPI master read data, valid while spi_rdy is high after a transaction.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, RELEASE.
REQ-016 IDLE: with any req bit set, SHALL select a winner, latch its cmd into spi_cmd, assert gnt[winner] and go to ISSUE next cycle; with no req, SHALL stay in IDLE with gnt=0.
REQ-017 With both req bits set in IDLE, SHALL grant the requester not served last (round-robin via last_gnt register).
REQ-018 ISSUE: SHALL assert spi_wrt for exactly one cycle, then go to WAIT.
REQ-019 WAIT: on spi_rdy=1, SHALL capture spi_rdata into rdata and go to RELEASE; otherwise SHALL stay in WAIT.
REQ-020 RELEASE: SHALL pulse done[winner] for one cycle, set gnt=0, update last_gnt=winner, and return to IDLE.
REQ-021 Latency: with req set in IDLE at cycle N, spi_wrt SHALL be high at N+1; done SHALL be high the cycle after spi_rdy is sampled high in WAIT.
REQ-022 spi_cmd and the winner SHALL remain stable from ISSUE through RELEASE regardless of changes on req/cmd0/cmd1.
REQ-023 A requester dropping req mid-transaction SHALL NOT abort it; done SHALL still pulse.
REQ-024 A req still high in the IDLE cycle after RELEASE SHALL be treated as a new request, with round-robin applied.
REQ-025 gnt SHALL never have more than one bit set; done SHALL only pulse for the bit currently granted.

Reset
REQ-026 On rst_n=0 at a clock edge, SHALL force state IDLE, gnt=0, done=0, err=0, spi_wrt=0, spi_cmd=0, rdata=0, and last_gnt=1 (requester 0 wins the first tie).
REQ-027 A reset mid-transaction SHALL abandon it without a done pulse or a reissued spi_wrt.

Configuration
REQ-028 With macro SPI_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT; if it reaches TO_CYCLES-1 with spi_rdy still low, SHALL go to RELEASE and pulse err together with done, leaving rdata unchanged.
REQ-029 Without SPI_ARB_TIMEOUT_EN: err SHALL be tied 0, no counter SHALL exist, and WAIT SHALL persist until spi_rdy is high.

Structure
REQ-030 Package spi_arb_pkg SHALL hold the state_t enum, NUM_REQ=2 and CMD_W=16.
REQ-031 Sub-module rr_pick SHALL implement the 2-way round-robin winner select from req and last_gnt.

Verification
REQ-032 Single request: req=01, cmd0=16'hA5C3 -> spi_wrt at N+1 with spi_cmd=A5C3; spi_rdy high with spi_rdata=16'h1234 -> done=01 next cycle, rdata=1234.
REQ-033 Tie after reset: req=11 -> gnt=01 first; both held -> next grant gnt=10, then gnt=01 (alternating).
REQ-034 Mid-transaction change: in WAIT, req0 drops and cmd0 changes to 16'hFFFF -> spi_cmd stays A5C3 and done[0] still pulses.
REQ-035 Reset in WAIT: rst_n low for 1 cycle -> all outputs 0, no done; next req=10 -> gnt=10.
REQ-036 With SPI_ARB_TIMEOUT_EN and TO_CYCLES=8: spi_rdy held low -> done and err pulse 8 cycles after WAIT entry, rdata unchanged; without the macro -> still in WAIT after 2000 cycles, err=0.
